// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle to capture the ALU outputs,
// then RESP holds the registered result until the consumer takes it.
// The architectural NZCV register is written only by setf requests.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_setf,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_setf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rslt,
    output logic [3:0]        rsp_checks,
    output logic [OP_W-1:0]   alu_ctrl,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [DATA_W-1:0] alu_in_2,
    input  logic [DATA_W-1:0] alu_rslt,
    input  logic [3:0]        alu_checks,
    output logic [3:0]        flags,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic                setf_q;
    logic                id_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [DATA_W-1:0]   rsp_rslt_q;
    logic [3:0]          rsp_checks_q;
    logic [3:0]          flags_q;

    logic                grant_vld_s;
    logic                grant_id_s;
    logic                req_fire_s;
    logic                rsp_fire_s;

    // Round-robin grant: contention goes to the port that did not win last.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = ~last_grant_q;
        end else if (req0_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b0;
        end else if (req1_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            grant_id_s  = 1'b0;
        end
    end

    assign req_fire_s = (state_q == IDLE) && grant_vld_s;
    assign rsp_fire_s = rsp_valid_q && rsp_ready;
    assign req0_ready = req_fire_s && !grant_id_s;
    assign req1_ready = req_fire_s && grant_id_s;

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP, RESP -> IDLE on take.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_fire_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_fire_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch: operands are sampled only on the accept edge and then
    // held, so the ALU inputs stay stable in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= {OP_W{1'b0}};
            a_q          <= {DATA_W{1'b0}};
            b_q          <= {DATA_W{1'b0}};
            setf_q       <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (req_fire_s) begin
            op_q         <= grant_id_s ? req1_op   : req0_op;
            a_q          <= grant_id_s ? req1_a    : req0_a;
            b_q          <= grant_id_s ? req1_b    : req0_b;
            setf_q       <= grant_id_s ? req1_setf : req0_setf;
            id_q         <= grant_id_s;
            last_grant_q <= grant_id_s;
        end
    end

    // Response and flag capture: ALU outputs are taken verbatim in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_rslt_q   <= {DATA_W{1'b0}};
            rsp_checks_q <= 4'b0000;
            flags_q      <= 4'b0000;
        end else if (state_q == EXEC) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_rslt_q   <= alu_rslt;
            rsp_checks_q <= alu_checks;
            if (setf_q) begin
                flags_q <= alu_checks;
            end
        end else if (rsp_fire_s) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign alu_ctrl   = op_q;
    assign alu_in_1   = a_q;
    assign alu_in_2   = b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_rslt   = rsp_rslt_q;
    assign rsp_checks = rsp_checks_q;
    assign flags      = flags_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to its ALU port.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_setf;
    logic [1:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_setf;
    logic [1:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_rslt;
    logic [3:0]  rsp_checks;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_in_1, alu_in_2, alu_rslt;
    logic [3:0]  alu_checks;
    logic [3:0]  flags;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.DATA_W(32), .OP_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_setf(req0_setf),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_setf(req1_setf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rslt(rsp_rslt), .rsp_checks(rsp_checks),
        .alu_ctrl(alu_ctrl), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_rslt(alu_rslt), .alu_checks(alu_checks),
        .flags(flags), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: ADD/SUB/AND/OR with {N,Z,C,V}; SUB carry = NOT borrow.
    always_comb begin
        logic [32:0] wide;
        logic c, v;
        wide = 33'd0;
        c = 1'b0;
        v = 1'b0;
        case (alu_ctrl)
            2'b00: begin
                wide = {1'b0, alu_in_1} + {1'b0, alu_in_2};
                c = wide[32];
                v = (alu_in_1[31] == alu_in_2[31]) && (wide[31] != alu_in_1[31]);
            end
            2'b01: begin
                wide = {1'b0, alu_in_1} - {1'b0, alu_in_2};
                c = (alu_in_1 >= alu_in_2);
                v = (alu_in_1[31] != alu_in_2[31]) && (wide[31] != alu_in_1[31]);
            end
            2'b10: wide = {1'b0, alu_in_1 & alu_in_2};
            default: wide = {1'b0, alu_in_1 | alu_in_2};
        endcase
        alu_rslt   = wide[31:0];
        alu_checks = {wide[31], (wide[31:0] == 32'd0), c, v};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One isolated operation on one port with rsp_ready high.
    task automatic run_op(input string tag, input bit port, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic setf,
                          input logic [31:0] er, input logic [3:0] ec, input logic [3:0] ef);
        int n;
        if (port) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_setf = setf;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_setf = setf;
        end
        #1;
        chk({tag, "_rdy"},   32'(port ? req1_ready : req0_ready), 32'd1);
        chk({tag, "_other"}, 32'(port ? req0_ready : req1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(op));
        chk({tag, "_in1"},  alu_in_1, a);
        chk({tag, "_in2"},  alu_in_2, b);
        n = 1;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"},    32'(n), 32'd2);
        chk({tag, "_id"},     32'(rsp_id), 32'(port));
        chk({tag, "_rslt"},   rsp_rslt, er);
        chk({tag, "_checks"}, 32'(rsp_checks), 32'(ec));
        chk({tag, "_flags"},  32'(flags), 32'(ef));
        @(negedge clk);
        chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gr_id[4];
        int gr_cyc[4];
        int ngr;
        int nrsp;
        int n;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = 32'd0; req0_b = 32'd0; req0_setf = 1'b0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = 32'd0; req1_b = 32'd0; req1_setf = 1'b0;
        rsp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid",  32'(rsp_valid), 32'd0);
        chk("rst_id",     32'(rsp_id), 32'd0);
        chk("rst_rslt",   rsp_rslt, 32'd0);
        chk("rst_checks", 32'(rsp_checks), 32'd0);
        chk("rst_flags",  32'(flags), 32'd0);
        chk("rst_ctrl",   32'(alu_ctrl), 32'd0);
        chk("rst_in1",    alu_in_1, 32'd0);
        chk("rst_in2",    alu_in_2, 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        rst_n = 1'b1;

        // ADD overflow with setf, then SUB equal without setf
        run_op("add_ovf", 1'b0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1,
               32'h8000_0000, 4'b1001, 4'b1001);
        run_op("sub_eq", 1'b1, 2'b01, 32'd5, 32'd5, 1'b0,
               32'h0000_0000, 4'b0110, 4'b1001);

        // Continuous contention: grants 0,1,0,1 three cycles apart
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'd10;   req0_b = 32'd20;   req0_setf = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'h0F;   req1_b = 32'hF0;   req1_setf = 1'b0;
        ngr = 0;
        nrsp = 0;
        for (int cyc = 0; cyc < 40 && ngr < 4; cyc++) begin
            #1;
            chk("cont_excl", 32'(req0_ready & req1_ready), 32'd0);
            if (rsp_valid && nrsp < 4) begin
                chk("cont_rsp_id", 32'(rsp_id), 32'(gr_id[nrsp]));
                chk("cont_rsp_rslt", rsp_rslt, (gr_id[nrsp] == 1) ? 32'h0000_00FF : 32'd30);
                nrsp++;
            end
            if (req0_ready || req1_ready) begin
                gr_id[ngr]  = req1_ready ? 1 : 0;
                gr_cyc[ngr] = cyc;
                ngr++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 10 && nrsp < 4; k++) begin
            #1;
            if (rsp_valid && nrsp < ngr) begin
                chk("cont_rsp_id", 32'(rsp_id), 32'(gr_id[nrsp]));
                chk("cont_rsp_rslt", rsp_rslt, (gr_id[nrsp] == 1) ? 32'h0000_00FF : 32'd30);
                nrsp++;
            end
            @(negedge clk);
        end
        chk("cont_ngrants", 32'(ngr), 32'd4);
        chk("cont_nrsp", 32'(nrsp), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_order", 32'(gr_id[i]), 32'(i % 2));
        end
        for (int i = 1; i < 4; i++) begin
            chk("cont_spacing", 32'(gr_cyc[i] - gr_cyc[i-1]), 32'd3);
        end
        chk("cont_flags", 32'(flags), 32'(4'b1001));
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end

        // Back-pressure: response held for 5 cycles, pending req0 waits
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'd3; req0_b = 32'd4; req0_setf = 1'b0;
        #1;
        chk("bp_rdy", 32'(req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_a = 32'd100;
        req0_b = 32'd1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rslt",  rsp_rslt, 32'd7);
            chk("bp_id",    32'(rsp_id), 32'd0);
            chk("bp_hold_rdy", 32'(req0_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rdy_in_resp", 32'(req0_ready), 32'd0);
        @(negedge clk);
        chk("bp_rdy_after", 32'(req0_ready), 32'd1);
        chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("bp_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("bp2_valid", 32'(rsp_valid), 32'd1);
        chk("bp2_rslt", rsp_rslt, 32'd101);
        chk("bp2_flags", 32'(flags), 32'(4'b1001));
        @(negedge clk);

        // Reset during EXEC discards the op and clears flags
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'hF0F0_F0F0; req0_b = 32'h0F0F_0F0F; req0_setf = 1'b1;
        #1;
        chk("mid_rdy", 32'(req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("mid_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        #1;
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_flags", 32'(flags), 32'd0);
        chk("mid_busy",  32'(busy), 32'd0);
        chk("mid_in1",   alu_in_1, 32'd0);
        @(negedge clk);
        chk("mid_valid2", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;

        // After reset port 0 wins contention: OR 0|0 then AND with setf
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'd0; req0_b = 32'd0; req0_setf = 1'b1;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'hFFFF_FFFF; req1_b = 32'h8000_0000; req1_setf = 1'b1;
        #1;
        chk("post_rdy0", 32'(req0_ready), 32'd1);
        chk("post_rdy1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("or_id",    32'(rsp_id), 32'd0);
        chk("or_rslt",  rsp_rslt, 32'd0);
        chk("or_flags", 32'(flags), 32'(4'b0100));
        @(negedge clk);
        chk("and_rdy", 32'(req1_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("and_id",     32'(rsp_id), 32'd1);
        chk("and_rslt",   rsp_rslt, 32'h8000_0000);
        chk("and_checks", 32'(rsp_checks), 32'(4'b1000));
        chk("and_flags",  32'(flags), 32'(4'b1000));
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
